// File: rtl/sw_conditioner.sv
// -----------------------------------------------------------------------------
// sw_conditioner
//
// Front end for the LED up/down counter stage.
// - Every raw slide switch passes through a two-flop synchroniser.
// - Each synchronised bit is then debounced on its own, giving a clean level
//   plus one-cycle rise and fall pulses.
// - A free-running prescaler generates a slow one-cycle count-enable tick.
// All outputs are registered in the clk domain.
//
// Parameters:
//   NSW         number of switches conditioned
//   DEB_CYCLES  consecutive differing cycles before the clean level follows (>= 1)
//   TICK_DIV    tick period in clk cycles (>= 2)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   sw_raw    in   raw asynchronous switch levels [NSW]
//   sw_clean  out  debounced switch levels [NSW]
//   sw_rise   out  one-cycle pulse on a clean 0->1 change [NSW]
//   sw_fall   out  one-cycle pulse on a clean 1->0 change [NSW]
//   tick      out  one-cycle count enable, one per TICK_DIV cycles
//
// Optional build macro: SW_CONDITIONER_TICK_RESTART_EN
//   When defined, any rise or fall pulse restarts the prescaler and masks the
//   tick in that cycle. The first count after a switch change therefore
//   always waits a full period.
// -----------------------------------------------------------------------------
module sw_conditioner #(
   parameter int NSW        = 3,
   parameter int DEB_CYCLES = 500000,
   parameter int TICK_DIV   = 25000000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NSW-1:0] sw_raw,
   output logic [NSW-1:0] sw_clean,
   output logic [NSW-1:0] sw_rise,
   output logic [NSW-1:0] sw_fall,
   output logic           tick
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
   localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);

   logic [NSW-1:0] s1_q, s2_q;
   logic [NSW-1:0] clean_q, clean_d;
   logic [NSW-1:0] rise_q, rise_d;
   logic [NSW-1:0] fall_q, fall_d;
   logic [CW-1:0]  cnt_q [NSW];
   logic [CW-1:0]  cnt_d [NSW];
   logic [PW-1:0]  pcnt_q, pcnt_d;
   logic           tick_q, tick_d;

   // Per-bit debounce.
   // - The counter only runs while the synchronised level disagrees with the
   //   clean level.
   // - Any agreement clears the counter, so a short glitch leaves no trace.
   // - On the final count the clean level flips and its pulse fires.
   always_comb begin
      clean_d = clean_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < NSW; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != clean_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               clean_d[i] = s2_q[i];
               rise_d[i]  = s2_q[i];
               fall_d[i]  = ~s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Prescaler: the tick is registered from the terminal count. The first
   // tick therefore appears after the TICK_DIV-th edge following reset.
   always_comb begin
      pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PW'(1);
      tick_d = (pcnt_q == PCNT_LAST);
`ifdef SW_CONDITIONER_TICK_RESTART_EN
      if (|{rise_d, fall_d}) begin
         pcnt_d = '0;
         tick_d = 1'b0;
      end
`else
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         clean_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         pcnt_q  <= '0;
         tick_q  <= 1'b0;
         for (int i = 0; i < NSW; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q    <= sw_raw;
         s2_q    <= s1_q;
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         pcnt_q  <= pcnt_d;
         tick_q  <= tick_d;
         for (int i = 0; i < NSW; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign sw_clean = clean_q;
   assign sw_rise  = rise_q;
   assign sw_fall  = fall_q;
   assign tick     = tick_q;

endmodule

// File: tb/tb_sw_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sw_conditioner
//
// Directed bench for sw_conditioner with NSW=3, DEB_CYCLES=4, TICK_DIV=5.
// - Each step pushes the expected per-cycle word {sw_clean, sw_rise, sw_fall,
//   tick} onto exp_q.
// - The step then pops and compares one word per clock, sampled 1 time unit
//   after the rising edge.
// - Expected ticks come from the edge count since reset release: high after
//   edges 5, 10, 15 and so on.
// -----------------------------------------------------------------------------
module tb_sw_conditioner;

   logic       clk;
   logic       rst_n;
   logic [2:0] sw_raw;
   logic [2:0] sw_clean, sw_rise, sw_fall;
   logic       tick;

   logic [9:0] exp_q[$];
   int         assert_cnt = 0;
   int         fail_cnt   = 0;
   int         pcyc       = 0;   // edges since reset release
   int         ticks      = 0;

   sw_conditioner #(.NSW(3), .DEB_CYCLES(4), .TICK_DIV(5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_raw   (sw_raw),
      .sw_clean (sw_clean),
      .sw_rise  (sw_rise),
      .sw_fall  (sw_fall),
      .tick     (tick)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard helpers
   task automatic push_n(input int n, input logic [2:0] c, input logic [2:0] r,
                         input logic [2:0] f);
      for (int i = 0; i < n; i++) begin
         pcyc++;
         exp_q.push_back({c, r, f, (pcyc % 5 == 0)});
      end
   endtask

   task automatic push_rst(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(10'b0);
   endtask

   task automatic check_cycle(input string tag);
      logic [9:0] exp, act;
      @(posedge clk);
      #1;
      act = {sw_clean, sw_rise, sw_fall, tick};
      assert_cnt++;
      if (exp_q.size() == 0) begin
         fail_cnt++;
         $error("FAIL %s: observed %b but scoreboard empty", tag, act);
      end else begin
         exp = exp_q.pop_front();
         assert (act === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp);
         end
      end
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) check_cycle(tag);
   endtask

   // Directed sequence
   initial begin
      logic [9:0] act;
      rst_n  = 1'b0;
      sw_raw = 3'b000;
      #1;
      act = {sw_clean, sw_rise, sw_fall, tick};
      assert_cnt++;
      assert (act === 10'b0) else begin
         fail_cnt++;
         $error("FAIL reset_init: observed %b expected %b", act, 10'b0);
      end

      // Reset held with the switches toggling: every output stays 0.
      for (int i = 0; i < 6; i++) begin
         push_rst(1);
         check_cycle("reset_hold");
         sw_raw = 3'($urandom_range(0, 7));
      end

      // Release with all switches low, then free-run with static switches.
      sw_raw = 3'b000;
      rst_n  = 1'b1;
      pcyc   = 0;
      push_n(20, 3'b000, 3'b000, 3'b000);
      for (int i = 0; i < 20; i++) begin
         check_cycle("free_run");
         if (tick === 1'b1) ticks++;
      end
      assert_cnt++;
      assert (ticks == 4) else begin
         fail_cnt++;
         $error("FAIL tick_count: observed %0d expected %0d", ticks, 4);
      end

      // sw_raw[0] 0->1: the clean level and the rise pulse appear on the
      // sixth edge, counting the first edge that samples the new level.
      sw_raw = 3'b001;
      push_n(5, 3'b000, 3'b000, 3'b000);
      push_n(1, 3'b001, 3'b001, 3'b000);
      push_n(4, 3'b001, 3'b000, 3'b000);
      run(10, "rise0");

      // sw_raw[0] 1->0: the fall pulse appears on the sixth edge.
      sw_raw = 3'b000;
      push_n(5, 3'b001, 3'b000, 3'b000);
      push_n(1, 3'b000, 3'b000, 3'b001);
      push_n(3, 3'b000, 3'b000, 3'b000);
      run(9, "fall0");

      // sw_raw[1] glitch held for three edges: no change and no pulse.
      sw_raw = 3'b010;
      push_n(3, 3'b000, 3'b000, 3'b000);
      run(3, "glitch_hi");
      sw_raw = 3'b000;
      push_n(8, 3'b000, 3'b000, 3'b000);
      run(8, "glitch_lo");

      // Two bits rising together pulse in the same cycle.
      sw_raw = 3'b101;
      push_n(5, 3'b000, 3'b000, 3'b000);
      push_n(1, 3'b101, 3'b101, 3'b000);
      push_n(3, 3'b101, 3'b000, 3'b000);
      run(9, "rise_101");

      // Start a falling debounce, then reset in the middle of it.
      sw_raw = 3'b000;
      push_n(3, 3'b101, 3'b000, 3'b000);
      run(3, "pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      act = {sw_clean, sw_rise, sw_fall, tick};
      assert_cnt++;
      assert (act === 10'b0) else begin
         fail_cnt++;
         $error("FAIL async_reset: observed %b expected %b", act, 10'b0);
      end
      sw_raw = 3'b111;
      push_rst(3);
      run(3, "reset_mid");

      // Release again: no pulse on release, and the tick grid restarts.
      sw_raw = 3'b000;
      rst_n  = 1'b1;
      pcyc   = 0;
      push_n(12, 3'b000, 3'b000, 3'b000);
      run(12, "post_reset");

      assert_cnt++;
      assert (exp_q.size() == 0) else begin
         fail_cnt++;
         $error("FAIL queue_drain: observed %0d entries expected %0d", exp_q.size(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/sw_conditioner.md
Name: sw_conditioner

Overview:
- Upstream front end for the LED up/down counter stage.
- Takes the raw slide switches, synchronises and debounces them, and produces clean levels plus one-cycle edge pulses.
- Also generates a slow one-cycle count-enable tick, so the downstream counter advances at a human-visible rate instead of every clk.
- All outputs are registered and in the clk domain.

Parameters:
- NSW, 3, number of switch inputs conditioned (bit 0 = direction, bit 1 = hold, bit 2 = display select in the default use).
- DEB_CYCLES, 500000, consecutive cycles a synchronised input must differ from the clean level before the clean level changes (10 ms at 50 MHz). Must be >= 1.
- TICK_DIV, 25000000, tick period in clk cycles (0.5 s at 50 MHz). Must be >= 2.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- sw_raw  in  NSW  raw, asynchronous switch levels.
- sw_clean  out  NSW  debounced switch levels.
- sw_rise  out  NSW  one-cycle pulse when the matching sw_clean bit goes 0->1.
- sw_fall  out  NSW  one-cycle pulse when the matching sw_clean bit goes 1->0.
- tick  out  1  one-cycle count-enable pulse, period TICK_DIV.

Behaviour:
- Reset (rst_n=0, asynchronous): the following are all cleared to 0 immediately and held at 0 while rst_n=0.
  - Both sync flops of every bit.
  - Debounce counters.
  - Prescaler.
  - sw_clean, sw_rise, sw_fall, tick.
- Synchroniser: two flops per bit; sw_raw -> s1 -> s2; s2 is the synchronised level.
- Debounce, per bit, independently:
  - s2 == sw_clean: debounce counter <= 0.
  - s2 != sw_clean and counter < DEB_CYCLES-1: counter increments.
  - s2 != sw_clean and counter == DEB_CYCLES-1: sw_clean <= s2, counter <= 0, and the matching rise/fall bit is asserted in the same cycle sw_clean changes.
  - Counter width is $clog2(DEB_CYCLES+1); it never exceeds DEB_CYCLES-1.
- Latency: a raw level held steady changes sw_clean exactly 2+DEB_CYCLES rising edges after the first edge that samples it.
- Glitch: if s2 returns to sw_clean before the threshold, the counter clears, sw_clean is unchanged, and no pulse is issued.
- Power-up with a switch already 1: sw_clean rises 2+DEB_CYCLES cycles after rst_n release, with a sw_rise pulse. Downstream logic must tolerate this.
- Edge pulses: sw_rise/sw_fall are high for exactly one cycle and are never both high on the same bit. Multiple bits may pulse in the same cycle.
- Prescaler:
  - Counter pcnt, width $clog2(TICK_DIV), counts 0..TICK_DIV-1 and wraps to 0.
  - tick <= (pcnt == TICK_DIV-1), registered.
  - First tick is high in the cycle following the TICK_DIV-th rising edge after reset release; thereafter exactly one high cycle per TICK_DIV cycles.
- tick is independent of the switches; hold/direction gating stays in the downstream counter.
- Reset mid-debounce or mid-period discards all progress; no pulse is emitted on reset assertion or release.

Optional Feature:
- Macro: SW_CONDITIONER_TICK_RESTART_EN.
- When defined: any sw_rise or sw_fall pulse on any bit forces pcnt <= 0 in that cycle, and tick is suppressed that cycle. The next tick then occurs a full TICK_DIV cycles after the switch change, so the first step after a direction change or hold release is a full period.
- When not defined: the prescaler free-runs and is unaffected by switch activity.

Test Plan:
- All tests use NSW=3, DEB_CYCLES=4, TICK_DIV=5.
- Reset held, sw_raw toggling -> all outputs 0 throughout. Release with sw_raw=3'b000 -> sw_clean stays 000, no pulses.
- sw_raw[0] 0->1 held -> sw_clean[0]=1 and sw_rise[0]=1 for one cycle, exactly 6 edges after the first sampling edge. Then 1->0 -> sw_fall[0] one cycle, 6 edges later.
- sw_raw[1] high for 3 cycles then low (glitch shorter than 2+4) -> sw_clean[1] stays 0, no sw_rise[1].
- Free run, switches static -> tick high 1 cycle in 5, first high after the 5th edge post-reset; 20 cycles yield exactly 4 ticks.
- sw_raw=3'b101 applied simultaneously -> sw_clean=101 with sw_rise=101 in the same cycle. Assert rst_n=0 mid-debounce of the next change -> outputs clear immediately.
- With SW_CONDITIONER_TICK_RESTART_EN: sw_rise[0] at pcnt=3 -> no tick that cycle, next tick 5 cycles after the pulse. Without the macro, the tick stays on the original 5-cycle grid.
